// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   NUM_REQ            : number of requesters sharing the execute datapath (fixed at 2)
//   FLAG_N..FLAG_V     : bit positions of the N, Z, C, V flags in a 4-bit flag vector
//   state_t            : arbiter FSM state encoding
package alu_arb_pkg;

    localparam int NUM_REQ = 2;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: request and response handshakes.
//   req_valid/req_ready            : per-requester request handshake
//   req_ctrl/alusrc/srca/wdata/imm : per-requester operation fields
//   resp_valid/resp_ready          : per-requester response handshake
//   resp_result/resp_flags         : shared response bus, qualified by resp_valid
//   req_lock                       : per-requester grant lock (only with ALU_ARB_LOCK_EN)
// Modports: master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    import alu_arb_pkg::*;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][3:0]       req_ctrl;
    logic [NUM_REQ-1:0]            req_alusrc;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_srca;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_imm;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [NUM_REQ-1:0]            resp_ready;
    logic [WIDTH-1:0]              resp_result;
    logic [3:0]                    resp_flags;
`ifdef ALU_ARB_LOCK_EN
    logic [NUM_REQ-1:0]            req_lock;
`endif

    modport master (
        output req_valid, req_ctrl, req_alusrc, req_srca, req_wdata, req_imm, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_flags
`ifdef ALU_ARB_LOCK_EN
        , output req_lock
`endif
    );

    modport slave (
        input  req_valid, req_ctrl, req_alusrc, req_srca, req_wdata, req_imm, resp_ready,
        output req_ready, resp_valid, resp_result, resp_flags
`ifdef ALU_ARB_LOCK_EN
        , input req_lock
`endif
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Combinational 2-way round-robin arbiter with optional grant lock.
//   valid       : request vector
//   last_grant  : index granted most recently; loses a tie
//   lock_active : when high only lock_idx may be granted
//   lock_idx    : requester holding the lock
//   grant       : one-hot or zero grant
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       lock_active,
    input  logic       lock_idx,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (lock_active) begin
            grant[lock_idx] = valid[lock_idx];
        end else if (&valid) begin
            grant[~last_grant] = 1'b1;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one execute datapath (SrcB mux + ALU) between two requesters.
// An accepted operation is latched, presented to the datapath for one EXEC
// cycle, and its result/flags are registered and held until the owning
// requester accepts the response.
//   clk, reset            : clock, synchronous active-high reset
//   bus                   : requester handshake bus (alu_arbiter_if.slave)
//   ALUSrcE, ALUControlE,
//   SrcAE, WriteDataE,
//   ExtImmE               : latched operands to the execute datapath
//   ALUResultE, ALUFlags  : combinational result/flags from the datapath
//   busy                  : high in any state other than IDLE
// Optional feature: define ALU_ARB_LOCK_EN to add bus.req_lock grant locking.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = alu_arb_pkg::NUM_REQ
) (
    input  logic              clk,
    input  logic              reset,
    alu_arbiter_if.slave      bus,
    output logic              ALUSrcE,
    output logic [3:0]        ALUControlE,
    output logic [WIDTH-1:0]  SrcAE,
    output logic [WIDTH-1:0]  WriteDataE,
    output logic [WIDTH-1:0]  ExtImmE,
    input  logic [WIDTH-1:0]  ALUResultE,
    input  logic [3:0]        ALUFlags,
    output logic              busy
);

    if (NUM_REQ != 2) begin : g_num_req_check
        $error("alu_arbiter supports exactly 2 requesters");
    end

    state_t     state;
    logic       gnt_idx;
    logic       last_grant;
    logic       lock_active;
    logic [1:0] grant;
    logic       win_idx;

    rr_arbiter2 u_rr (
        .valid       (bus.req_valid),
        .last_grant  (last_grant),
        .lock_active (lock_active),
        .lock_idx    (gnt_idx),
        .grant       (grant)
    );

    assign win_idx = grant[1];

    // Reset gates req_ready so nothing can handshake during a reset cycle.
    assign bus.req_ready  = (state == IDLE && !reset) ? grant : '0;
    assign bus.resp_valid = (state == RESP) ? (2'b01 << gnt_idx) : '0;
    assign busy           = (state != IDLE);

`ifndef ALU_ARB_LOCK_EN
    assign lock_active = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            gnt_idx         <= 1'b0;
            last_grant      <= 1'b1;
            ALUSrcE         <= 1'b0;
            ALUControlE     <= '0;
            SrcAE           <= '0;
            WriteDataE      <= '0;
            ExtImmE         <= '0;
            bus.resp_result <= '0;
            bus.resp_flags  <= '0;
`ifdef ALU_ARB_LOCK_EN
            lock_active     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        ALUSrcE     <= bus.req_alusrc[win_idx];
                        ALUControlE <= bus.req_ctrl[win_idx];
                        SrcAE       <= bus.req_srca[win_idx];
                        WriteDataE  <= bus.req_wdata[win_idx];
                        ExtImmE     <= bus.req_imm[win_idx];
                        gnt_idx     <= win_idx;
                        last_grant  <= win_idx;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    bus.resp_result <= ALUResultE;
                    bus.resp_flags  <= ALUFlags;
                    state           <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready[gnt_idx]) begin
`ifdef ALU_ARB_LOCK_EN
                        // The lock is both taken and released at response handshake.
                        lock_active <= bus.req_lock[gnt_idx];
`endif
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a model adder datapath.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ALUSrcE;
    logic [3:0]        ALUControlE;
    logic [WIDTH-1:0]  SrcAE, WriteDataE, ExtImmE;
    logic [WIDTH-1:0]  ALUResultE;
    logic [3:0]        ALUFlags;
    logic              busy;

    logic [WIDTH-1:0]  bsel;
    logic [WIDTH:0]    sum;

    int errors = 0;
    int checks = 0;

    alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu_arbiter #(.WIDTH(WIDTH), .NUM_REQ(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .ALUSrcE     (ALUSrcE),
        .ALUControlE (ALUControlE),
        .SrcAE       (SrcAE),
        .WriteDataE  (WriteDataE),
        .ExtImmE     (ExtImmE),
        .ALUResultE  (ALUResultE),
        .ALUFlags    (ALUFlags),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Model execute datapath: SrcA + SrcB with N,Z,C,V from the sum.
    always_comb begin
        bsel       = ALUSrcE ? ExtImmE : WriteDataE;
        sum        = {1'b0, SrcAE} + {1'b0, bsel};
        ALUResultE = sum[WIDTH-1:0];
        ALUFlags   = '0;
        ALUFlags[FLAG_N] = sum[WIDTH-1];
        ALUFlags[FLAG_Z] = (sum[WIDTH-1:0] == '0);
        ALUFlags[FLAG_C] = sum[WIDTH];
        ALUFlags[FLAG_V] = (SrcAE[WIDTH-1] == bsel[WIDTH-1]) && (sum[WIDTH-1] != SrcAE[WIDTH-1]);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic v, input logic [3:0] ctrl, input logic alusrc,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] im);
        bus.req_valid[idx]  = v;
        bus.req_ctrl[idx]   = ctrl;
        bus.req_alusrc[idx] = alusrc;
        bus.req_srca[idx]   = a;
        bus.req_wdata[idx]  = wd;
        bus.req_imm[idx]    = im;
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_ctrl   = '0;
        bus.req_alusrc = '0;
        bus.req_srca   = '0;
        bus.req_wdata  = '0;
        bus.req_imm    = '0;
        bus.resp_ready = '0;
`ifdef ALU_ARB_LOCK_EN
        bus.req_lock   = '0;
`endif

        // Reset state
        tick(); tick();
        check("rst_req_ready", 64'(bus.req_ready), 64'h0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_result", 64'(bus.resp_result), 64'h0);
        check("rst_flags", 64'(bus.resp_flags), 64'h0);
        check("rst_srca", 64'(SrcAE), 64'h0);
        reset = 1'b0;

        // Single req0: 5 + 7
        set_req(0, 1'b1, 4'h0, 1'b0, 32'd5, 32'd7, 32'd99);
        #1;
        check("t1_req_ready", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid[0] = 1'b0;
        check("t1_exec_busy", 64'(busy), 64'h1);
        check("t1_exec_rdy", 64'(bus.req_ready), 64'h0);
        check("t1_exec_srca", 64'(SrcAE), 64'd5);
        check("t1_exec_wdata", 64'(WriteDataE), 64'd7);
        check("t1_exec_rvalid", 64'(bus.resp_valid), 64'h0);
        tick();
        check("t1_resp_valid", 64'(bus.resp_valid), 64'h1);
        check("t1_resp_result", 64'(bus.resp_result), 64'd12);
        check("t1_resp_flags", 64'(bus.resp_flags), 64'h0);
        bus.resp_ready = 2'b01;
        tick();
        check("t1_idle_busy", 64'(busy), 64'h0);
        check("t1_idle_rvalid", 64'(bus.resp_valid), 64'h0);
        bus.resp_ready = 2'b00;

        // Tie after reset goes to 0, then alternation 1,0,1 every 3 cycles
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        set_req(0, 1'b1, 4'h0, 1'b0, 32'd10, 32'd1, 32'd0);
        set_req(1, 1'b1, 4'hA, 1'b1, 32'd100, 32'd999, 32'd20);
        bus.resp_ready = 2'b11;
        #1;
        check("t2_tie_grant0", 64'(bus.req_ready), 64'h1);
        tick(); tick();
        check("t2_r0_valid", 64'(bus.resp_valid), 64'h1);
        check("t2_r0_result", 64'(bus.resp_result), 64'd11);
        tick();
        check("t2_grant1", 64'(bus.req_ready), 64'h2);
        tick();
        check("t2_ctrl1", 64'(ALUControlE), 64'hA);
        check("t2_imm1", 64'(ExtImmE), 64'd20);
        tick();
        check("t2_r1_valid", 64'(bus.resp_valid), 64'h2);
        check("t2_r1_result", 64'(bus.resp_result), 64'd120);
        tick();
        check("t2_grant0", 64'(bus.req_ready), 64'h1);
        tick(); tick();
        check("t2_r0b_valid", 64'(bus.resp_valid), 64'h1);
        check("t2_r0b_result", 64'(bus.resp_result), 64'd11);
        tick();
        check("t2_grant1b", 64'(bus.req_ready), 64'h2);
        bus.req_valid = 2'b00;
        bus.resp_ready = 2'b00;
        #1;
        check("t2_drop_nogrant", 64'(bus.req_ready), 64'h0);
        tick();
        check("t2_drop_idle", 64'(busy), 64'h0);

        // Req1: 0xFFFFFFFF + 1 -> 0 with Z and C
        set_req(1, 1'b1, 4'h0, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1);
        #1;
        check("t3_grant1", 64'(bus.req_ready), 64'h2);
        tick();
        check("t3_exec_rdy", 64'(bus.req_ready), 64'h0);
        tick();
        check("t3_resp_valid", 64'(bus.resp_valid), 64'h2);
        check("t3_result", 64'(bus.resp_result), 64'h0);
        check("t3_flags", 64'(bus.resp_flags), 64'h6);
        check("t3_resp_rdy", 64'(bus.req_ready), 64'h0);

        // Stall in RESP; resp_ready on the other index is ignored
        bus.req_valid[1] = 1'b0;
        set_req(0, 1'b1, 4'h0, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0);
        bus.resp_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_valid", 64'(bus.resp_valid), 64'h2);
            check("t4_hold_result", 64'(bus.resp_result), 64'h0);
            check("t4_hold_rdy", 64'(bus.req_ready), 64'h0);
        end
        bus.resp_ready = 2'b10;
        tick();
        check("t4_rel_busy", 64'(busy), 64'h0);
        check("t4_rel_rvalid", 64'(bus.resp_valid), 64'h0);
        check("t4_rel_grant0", 64'(bus.req_ready), 64'h1);
        bus.resp_ready = 2'b00;
        tick();
        bus.req_valid[0] = 1'b0;
        tick();
        check("t4_ovf_result", 64'(bus.resp_result), 64'h8000_0000);
        check("t4_ovf_flags", 64'(bus.resp_flags), 64'h9);
        bus.resp_ready = 2'b01;
        tick();
        bus.resp_ready = 2'b00;

        // Reset during EXEC aborts; req0 then wins the tie again
        set_req(0, 1'b1, 4'h0, 1'b0, 32'd3, 32'd4, 32'd0);
        bus.req_valid[1] = 1'b1;
        #1;
        check("t5_grant1", 64'(bus.req_ready), 64'h2);
        tick();
        check("t5_exec_busy", 64'(busy), 64'h1);
        reset = 1'b1;
        tick();
        check("t5_rst_rvalid", 64'(bus.resp_valid), 64'h0);
        check("t5_rst_busy", 64'(busy), 64'h0);
        check("t5_rst_rdy", 64'(bus.req_ready), 64'h0);
        check("t5_rst_result", 64'(bus.resp_result), 64'h0);
        reset = 1'b0;
        #1;
        check("t5_tie_grant0", 64'(bus.req_ready), 64'h1);
        tick(); tick();
        check("t5_r0_valid", 64'(bus.resp_valid), 64'h1);
        check("t5_r0_result", 64'(bus.resp_result), 64'd7);
        bus.resp_ready = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        bus.resp_ready = 2'b00;

`ifdef ALU_ARB_LOCK_EN
        // Lock keeps req0 granted while req1 waits
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        bus.req_lock = 2'b01;
        bus.req_valid = 2'b11;
        bus.resp_ready = 2'b11;
        #1;
        check("lk_first0", 64'(bus.req_ready), 64'h1);
        tick(); tick(); tick();
        check("lk_locked0", 64'(bus.req_ready), 64'h1);
        bus.req_lock = 2'b00;
        tick(); tick(); tick();
        check("lk_release1", 64'(bus.req_ready), 64'h2);
        bus.req_valid = 2'b00;
        bus.resp_ready = 2'b00;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
